// File: rtl/cr_osf_egress_if.sv
// Beat type and handshake bundle for cr_osf_egress.
// master = the egress block, slave = the FIFO/downstream side.
package cr_osf_egress_pkg;
  typedef struct packed {
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic [1:0]  tuser;
  } axi4s_dp_bus_t;
endpackage

interface cr_osf_egress_if #(parameter int CNT_W = 32);
  import cr_osf_egress_pkg::*;

  axi4s_dp_bus_t    ob_fifo_rdata;
  logic             ob_fifo_empty;
  logic             ob_fifo_rd;
  axi4s_dp_bus_t    osf_ob_out;
  logic             osf_ob_out_valid;
  logic             osf_ob_out_rdy;
  logic [CNT_W-1:0] tlv_cnt;
  logic [1:0]       framing_err;
  logic             stat_clr;

  modport master (
    input  ob_fifo_rdata, ob_fifo_empty, osf_ob_out_rdy, stat_clr,
    output ob_fifo_rd, osf_ob_out, osf_ob_out_valid, tlv_cnt, framing_err
  );

  modport slave (
    output ob_fifo_rdata, ob_fifo_empty, osf_ob_out_rdy, stat_clr,
    input  ob_fifo_rd, osf_ob_out, osf_ob_out_valid, tlv_cnt, framing_err
  );
endinterface

// File: rtl/cr_osf_egress.sv
// Egress skid buffer (output slot + spare slot) with optional TLV framing stats.
// Define CR_OSF_EGRESS_STATS_EN to build the framing FSM, tlv_cnt and framing_err.
module cr_osf_egress
  import cr_osf_egress_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic             clk,
  input logic             rst,
  cr_osf_egress_if.master bus
);

  axi4s_dp_bus_t r_out;
  axi4s_dp_bus_t r_spare;
  logic          r_out_vld;
  logic          r_spare_vld;
  logic          w_pop;
  logic          w_xfer;

  // Popping depends only on the spare slot, so rd never waits on downstream ready.
  assign w_pop                = !rst && !bus.ob_fifo_empty && !r_spare_vld;
  assign w_xfer               = r_out_vld && bus.osf_ob_out_rdy;
  assign bus.ob_fifo_rd       = w_pop;
  assign bus.osf_ob_out       = r_out;
  assign bus.osf_ob_out_valid = r_out_vld;

  // Skid buffer: output slot refills from the spare first, then from the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out       <= '0;
      r_spare     <= '0;
      r_out_vld   <= 1'b0;
      r_spare_vld <= 1'b0;
    end else if (!r_out_vld || w_xfer) begin
      if (r_spare_vld) begin
        r_out       <= r_spare;
        r_out_vld   <= 1'b1;
        r_spare_vld <= 1'b0;
      end else if (w_pop) begin
        r_out     <= bus.ob_fifo_rdata;
        r_out_vld <= 1'b1;
      end else begin
        r_out_vld <= 1'b0;
      end
    end else if (w_pop) begin
      r_spare     <= bus.ob_fifo_rdata;
      r_spare_vld <= 1'b1;
    end
  end

`ifdef CR_OSF_EGRESS_STATS_EN
  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_IN_TLV = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_tlv_cnt;
  logic [1:0]       r_framing_err;
  logic             w_sot;
  logic             w_eot;

  assign w_sot           = r_out.tuser[0];
  assign w_eot           = r_out.tuser[1];
  assign bus.tlv_cnt     = r_tlv_cnt;
  assign bus.framing_err = r_framing_err;

  // A beat without SOT while idle is still treated as a TLV start, so EOT alone decides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (w_xfer) begin
      r_state <= w_eot ? ST_IDLE : ST_IN_TLV;
    end
  end

  // Saturating TLV counter and sticky framing errors; stat_clr overrides updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tlv_cnt     <= '0;
      r_framing_err <= 2'b00;
    end else if (bus.stat_clr) begin
      r_tlv_cnt     <= '0;
      r_framing_err <= 2'b00;
    end else if (w_xfer) begin
      if (w_eot && (r_tlv_cnt != {CNT_W{1'b1}})) begin
        r_tlv_cnt <= r_tlv_cnt + CNT_ONE;
      end
      case (r_state)
        ST_IDLE: begin
          if (!w_sot) begin
            r_framing_err[1] <= 1'b1;
          end
        end
        ST_IN_TLV: begin
          if (w_sot) begin
            r_framing_err[0] <= 1'b1;
          end
        end
        default: begin
          r_framing_err <= r_framing_err;
        end
      endcase
    end
  end
`else
  assign bus.tlv_cnt     = '0;
  assign bus.framing_err = 2'b00;
`endif

endmodule

// File: tb/tb_cr_osf_egress.sv
// Randomized self-checking bench for cr_osf_egress against a queue-based reference model.
module tb_cr_osf_egress;
  import cr_osf_egress_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cr_osf_egress_if #(.CNT_W(CNT_W)) bus ();
  cr_osf_egress #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  axi4s_dp_bus_t src_q[$];
  axi4s_dp_bus_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_pop, n_xfer;
  bit m_in_tlv;
  int m_cnt;
  logic [1:0] m_err;

  function automatic axi4s_dp_bus_t mk_beat(input logic [1:0] tu);
    axi4s_dp_bus_t b;
    b.tdata = $urandom;
    b.tkeep = 4'($urandom_range(15, 0));
    b.tlast = tu[1];
    b.tuser = tu;
    return b;
  endfunction

  task automatic push(input logic [1:0] tu);
    axi4s_dp_bus_t b;
    b = mk_beat(tu);
    src_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic drive_fifo();
    bus.ob_fifo_empty = (src_q.size() == 0);
    bus.ob_fifo_rdata = (src_q.size() == 0) ? '0 : src_q[0];
  endtask

  // Expected stats from the framing rules, applied to each accepted beat.
  task automatic model_beat(input axi4s_dp_bus_t b);
`ifdef CR_OSF_EGRESS_STATS_EN
    if (!m_in_tlv && !b.tuser[0]) m_err[1] = 1'b1;
    if (m_in_tlv && b.tuser[0]) m_err[0] = 1'b1;
    m_in_tlv = !b.tuser[1];
    if (b.tuser[1] && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
`else
    m_in_tlv = !b.tuser[1];
`endif
  endtask

  // One clock: sample pre-edge handshake, advance, score and compare post-edge state.
  task automatic cycle();
    logic pre_rd, pre_vld, pre_rdy, pre_clr;
    axi4s_dp_bus_t pre_out, exp_b, got;
    #1;
    pre_rd = bus.ob_fifo_rd;
    pre_vld = bus.osf_ob_out_valid;
    pre_rdy = bus.osf_ob_out_rdy;
    pre_clr = bus.stat_clr;
    pre_out = bus.osf_ob_out;
    n_checks++;
    if (pre_rd && src_q.size() == 0) begin
      n_errors++; $display("FAIL pop_when_empty: rd=%0b expected 0", pre_rd);
    end
    @(posedge clk); #1;
    if (pre_rd && src_q.size() > 0) begin
      got = src_q.pop_front();
      n_pop++;
    end
    if (pre_vld && pre_rdy) begin
      n_xfer++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++; $display("FAIL extra_beat: got %0h expected none", pre_out);
      end else begin
        exp_b = exp_q.pop_front();
        if (pre_out !== exp_b) begin
          n_errors++; $display("FAIL beat_order: got %0h expected %0h", pre_out, exp_b);
        end
        model_beat(exp_b);
      end
    end
    if (pre_clr) begin
      m_cnt = 0;
      m_err = 2'b00;
    end
    if (pre_vld && !pre_rdy) begin
      n_checks++;
      if (bus.osf_ob_out_valid !== 1'b1 || bus.osf_ob_out !== pre_out) begin
        n_errors++;
        $display("FAIL stall_hold: got v=%0b d=%0h expected v=1 d=%0h",
                 bus.osf_ob_out_valid, bus.osf_ob_out, pre_out);
      end
    end
    n_checks++;
    if (n_pop - n_xfer > 2) begin
      n_errors++; $display("FAIL popped_ahead: got %0d expected <=2", n_pop - n_xfer);
    end
    n_checks++;
    if (bus.tlv_cnt !== CNT_W'(m_cnt) || bus.framing_err !== m_err) begin
      n_errors++;
      $display("FAIL stats: got cnt=%0d err=%0b expected cnt=%0d err=%0b",
               bus.tlv_cnt, bus.framing_err, m_cnt, m_err);
    end
    drive_fifo();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (exp_q.size() > 0 || bus.osf_ob_out_valid); i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.stat_clr = 1'b0;
    bus.osf_ob_out_rdy = 1'b0;
    src_q.delete();
    exp_q.delete();
    drive_fifo();
    m_in_tlv = 1'b0; m_cnt = 0; m_err = 2'b00;
    n_pop = 0; n_xfer = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stat_clr = 1'b0;
    bus.osf_ob_out_rdy = 1'b1;
    push(2'b01);
    drive_fifo();
    #3;
    n_checks++;
    if (bus.osf_ob_out_valid !== 1'b0 || bus.ob_fifo_rd !== 1'b0 || bus.osf_ob_out !== '0 ||
        bus.tlv_cnt !== '0 || bus.framing_err !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_state: got v=%0b rd=%0b d=%0h cnt=%0d err=%0b expected all 0",
               bus.osf_ob_out_valid, bus.ob_fifo_rd, bus.osf_ob_out, bus.tlv_cnt, bus.framing_err);
    end
    do_reset();
  endtask

  task automatic test_two_tlvs();
    do_reset();
    bus.osf_ob_out_rdy = 1'b1;
    for (int t = 0; t < 2; t++) begin
      push(2'b01); push(2'b00); push(2'b00); push(2'b10);
    end
    drive_fifo();
    cycle();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bus.osf_ob_out_valid !== 1'b1) begin
        n_errors++; $display("FAIL stream_valid: cycle %0d got 0 expected 1", i + 1);
      end
      cycle();
    end
    n_checks++;
    if (bus.osf_ob_out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL stream_end: got v=%0b left=%0d expected v=0 left=0",
               bus.osf_ob_out_valid, exp_q.size());
    end
    n_checks++;
`ifdef CR_OSF_EGRESS_STATS_EN
    if (bus.tlv_cnt !== 4'd2 || bus.framing_err !== 2'b00) begin
`else
    if (bus.tlv_cnt !== 4'd0 || bus.framing_err !== 2'b00) begin
`endif
      n_errors++;
      $display("FAIL two_tlv_stats: got cnt=%0d err=%0b", bus.tlv_cnt, bus.framing_err);
    end
  endtask

  task automatic test_stall_toggle();
    logic [3:0] pat;
    pat = 4'b1001;
    do_reset();
    for (int i = 0; i < 24; i++) push(2'($urandom_range(3, 0)));
    drive_fifo();
    for (int k = 0; k < 200 && (exp_q.size() > 0 || bus.osf_ob_out_valid); k++) begin
      bus.osf_ob_out_rdy = pat[k % 4];
      cycle();
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL toggle_drain: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    int pushed;
    do_reset();
    pushed = 0;
    for (int k = 0; k < 600 && (pushed < 60 || exp_q.size() > 0 || bus.osf_ob_out_valid); k++) begin
      if (pushed < 60 && $urandom_range(2, 0) != 0) begin
        push(2'($urandom_range(3, 0)));
        pushed++;
      end
      bus.osf_ob_out_rdy = 1'($urandom_range(1, 0));
      bus.stat_clr = ($urandom_range(15, 0) == 0);
      drive_fifo();
      cycle();
    end
    bus.stat_clr = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || pushed != 60) begin
      n_errors++; $display("FAIL random_drain: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_framing(input logic [1:0] tu0, input logic [1:0] tu1, input logic [1:0] exp_err);
    do_reset();
    bus.osf_ob_out_rdy = 1'b1;
    push(tu0); push(tu1); push(2'b10);
    drive_fifo();
    drain(50);
    n_checks++;
`ifdef CR_OSF_EGRESS_STATS_EN
    if (bus.framing_err !== exp_err || exp_q.size() != 0) begin
`else
    if (bus.framing_err !== 2'b00 || exp_q.size() != 0) begin
`endif
      n_errors++;
      $display("FAIL framing_err: got %0b expected %0b", bus.framing_err, exp_err);
    end
  endtask

  task automatic test_saturation();
    bit sat_seen;
    do_reset();
    sat_seen = 1'b0;
    bus.osf_ob_out_rdy = 1'b1;
    for (int i = 0; i < 17; i++) push(2'b11);
    drive_fifo();
    for (int k = 0; k < 100 && (exp_q.size() > 0 || bus.osf_ob_out_valid); k++) begin
      #1;
      bus.stat_clr = (n_xfer == 16) && bus.osf_ob_out_valid;
      if (n_xfer == 16 && !sat_seen) begin
        sat_seen = 1'b1;
        n_checks++;
`ifdef CR_OSF_EGRESS_STATS_EN
        if (bus.tlv_cnt !== 4'hF) begin
`else
        if (bus.tlv_cnt !== 4'h0) begin
`endif
          n_errors++; $display("FAIL cnt_saturate: got %0h expected F", bus.tlv_cnt);
        end
      end
      cycle();
    end
    bus.stat_clr = 1'b0;
    n_checks++;
    if (!sat_seen || bus.tlv_cnt !== 4'h0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL clr_wins: got cnt=%0h seen=%0b expected cnt=0", bus.tlv_cnt, sat_seen);
    end
  endtask

  task automatic test_reset_mid_tlv();
    do_reset();
    bus.osf_ob_out_rdy = 1'b1;
    push(2'b01); push(2'b00); push(2'b00); push(2'b00);
    drive_fifo();
    cycle();
    cycle();
    bus.osf_ob_out_rdy = 1'b0;
    cycle();
    n_checks++;
    if (bus.ob_fifo_rd !== 1'b0 || bus.osf_ob_out_valid !== 1'b1 || src_q.size() != 1) begin
      n_errors++;
      $display("FAIL slots_full: got rd=%0b v=%0b src=%0d expected rd=0 v=1 src=1",
               bus.ob_fifo_rd, bus.osf_ob_out_valid, src_q.size());
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.osf_ob_out_valid !== 1'b0 || bus.ob_fifo_rd !== 1'b0 || bus.osf_ob_out !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got v=%0b rd=%0b d=%0h expected 0",
               bus.osf_ob_out_valid, bus.ob_fifo_rd, bus.osf_ob_out);
    end
    src_q.delete(); exp_q.delete();
    m_in_tlv = 1'b0; m_cnt = 0; m_err = 2'b00; n_pop = 0; n_xfer = 0;
    drive_fifo();
    @(posedge clk); #1 rst = 1'b0;
    bus.osf_ob_out_rdy = 1'b1;
    cycle();
    n_checks++;
    if (bus.osf_ob_out_valid !== 1'b0 || bus.framing_err !== 2'b00) begin
      n_errors++;
      $display("FAIL post_reset_empty: got v=%0b err=%0b expected 0",
               bus.osf_ob_out_valid, bus.framing_err);
    end
    push(2'b01); push(2'b10);
    drive_fifo();
    drain(50);
    n_checks++;
`ifdef CR_OSF_EGRESS_STATS_EN
    if (bus.framing_err !== 2'b00 || bus.tlv_cnt !== 4'd1 || exp_q.size() != 0) begin
`else
    if (bus.framing_err !== 2'b00 || bus.tlv_cnt !== 4'd0 || exp_q.size() != 0) begin
`endif
      n_errors++;
      $display("FAIL post_reset_tlv: got err=%0b cnt=%0d", bus.framing_err, bus.tlv_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.stat_clr = 1'b0;
    bus.osf_ob_out_rdy = 1'b0;
    bus.ob_fifo_empty = 1'b1;
    bus.ob_fifo_rdata = '0;
    test_reset();
    test_two_tlvs();
    test_stall_toggle();
    test_random();
    test_framing(2'b01, 2'b01, 2'b01);
    test_framing(2'b00, 2'b00, 2'b10);
    test_saturation();
    test_reset_mid_tlv();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cr_osf_egress.md
CR_OSF_EGRESS -- requirements
Module: cr_osf_egress

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the width of the TLV counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port ob_fifo_rdata, input, axi4s_dp_bus_t: show-ahead head of the ob FIFO, valid whenever ob_fifo_empty=0.
REQ-005 SHALL have port ob_fifo_empty, input, 1 bit: the ob FIFO is empty.
REQ-006 SHALL have port ob_fifo_rd, output, 1 bit: pops the ob FIFO head this cycle.
REQ-007 SHALL have port osf_ob_out, output, axi4s_dp_bus_t: egress beat; tuser[0]=SOT, tuser[1]=EOT.
REQ-008 SHALL have port osf_ob_out_valid, output, 1 bit: the egress beat is valid.
REQ-009 SHALL have port osf_ob_out_rdy, input, 1 bit: downstream accepts the beat.
REQ-010 SHALL have port tlv_cnt, output, CNT_W bits: count of TLVs sent.
REQ-011 SHALL have port framing_err, output, 2 bits: sticky errors; [0] = SOT inside a TLV, [1] = beat outside a TLV without SOT.
REQ-012 SHALL have port stat_clr, input, 1 bit: clears tlv_cnt and framing_err.

Function
REQ-013 SHALL hold data in a 2-entry skid buffer: a registered output slot plus a spare slot.
REQ-014 SHALL assert ob_fifo_rd = !ob_fifo_empty && spare slot empty, so ob_fifo_rd does not depend combinationally on osf_ob_out_rdy.
REQ-015 SHALL complete a transfer when osf_ob_out_valid && osf_ob_out_rdy.
REQ-016 SHALL, when a beat is popped in cycle N and the output slot is free or transferring, present it on osf_ob_out with valid in cycle N+1, giving a minimum latency of 1.
REQ-017 SHALL load a popped beat into the spare slot when the output slot is occupied and not transferring.
REQ-018 SHALL, when the output slot transfers, refill it from the spare slot first, then from the FIFO.
REQ-019 SHALL sustain 1 beat per clock while the FIFO is non-empty and osf_ob_out_rdy=1.
REQ-020 SHALL hold osf_ob_out stable while osf_ob_out_valid=1 and osf_ob_out_rdy=0, and SHALL NOT drop valid until the transfer completes.
REQ-021 SHALL pass beats in order, unmodified.
REQ-022 SHALL run a framing FSM on transferred beats with states IDLE and IN_TLV:
  - IDLE, SOT and !EOT -> IN_TLV.
  - IDLE, SOT and EOT (single-beat TLV) -> stays IDLE.
  - IN_TLV, EOT -> IDLE.
  - IDLE, !SOT -> sets framing_err[1]; FSM then treats the beat as a TLV start.
  - IN_TLV, SOT -> sets framing_err[0]; FSM stays in IN_TLV, or goes to IDLE if EOT.
REQ-023 SHALL increment tlv_cnt by 1 on every transferred beat with EOT.
REQ-024 SHALL saturate tlv_cnt at all-ones and SHALL NOT wrap.
REQ-025 SHALL, when stat_clr is asserted in the same cycle as an increment or error, make stat_clr win: the counter and errors read 0 the next cycle.
REQ-026 SHALL NOT affect the FSM state or the datapath when stat_clr is asserted.
REQ-027 SHALL NOT pop the FIFO when it is empty, regardless of buffer state.

Reset
REQ-028 SHALL, while rst=1, asynchronously clear both slots and drive osf_ob_out_valid=0, ob_fifo_rd=0, FSM=IDLE, tlv_cnt=0, framing_err=0, osf_ob_out=0.
REQ-029 SHALL, when rst is asserted mid-TLV, discard buffered beats and leave no error recorded after reset.
REQ-030 SHALL perform the first pop no earlier than the first clock edge after rst deasserts.

Configuration
REQ-031 SHALL, when CR_OSF_EGRESS_STATS_EN is defined, implement the framing FSM, tlv_cnt and framing_err as in REQ-022..REQ-026.
REQ-032 SHALL, when CR_OSF_EGRESS_STATS_EN is undefined, omit the FSM and counter logic and tie tlv_cnt=0 and framing_err=0, with stat_clr ignored and the datapath unchanged.

Verification
REQ-033 SHALL cover this scenario: FIFO holds 8 beats forming 2 TLVs of 4 beats, osf_ob_out_rdy=1 -> valid from cycle 1 for 8 consecutive cycles, tlv_cnt=2, framing_err=0.
REQ-034 SHALL cover this scenario: continuous stream, osf_ob_out_rdy toggling 1,0,0,1 -> no beat lost or duplicated, data stable during stall, at most 2 beats popped ahead of acceptance.
REQ-035 SHALL cover this scenario: beat with tuser=2'b01 followed by beat with tuser=2'b01 -> framing_err=2'b01.
REQ-036 SHALL cover this scenario: first beat after reset with tuser=2'b00 -> framing_err=2'b10.
REQ-037 SHALL cover this scenario: CNT_W=4, 17 single-beat TLVs (tuser=2'b11) -> tlv_cnt=4'hF; stat_clr coincident with the 17th EOT -> 0.
REQ-038 SHALL cover this scenario: rst pulsed mid-TLV with both slots full -> valid=0 immediately and asynchronously, empty buffers, FSM=IDLE; the next SOT beat raises no error.
